// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings and helpers for the dmem_cache data cache.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int OFFSET_BITS = 4;

    localparam logic [1:0] MC_BYTE = 2'b00;
    localparam logic [1:0] MC_HALF = 2'b01;
    localparam logic [1:0] MC_WORD = 2'b10;
    localparam int         MC_UNSIGNED = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        BYPASS = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            MC_BYTE: return 1'b0;
            MC_HALF: return lsb[0];
            default: return lsb != 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_cache_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Selects the addressed byte/half of a word and sign/zero extends it.
// Revision : 1.0
// ============================================================================
module load_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            lsb_i,
    input  logic [2:0]            ctrl_i,
    output logic [DATA_WIDTH-1:0] rd_o
);
    import dmem_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[{lsb_i, 3'b000} +: 8];
        w_half = word_i[{lsb_i[1], 4'b0000} +: 16];
        rd_o   = word_i;
        case (ctrl_i[1:0])
            MC_BYTE: rd_o = ctrl_i[MC_UNSIGNED] ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                                : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            MC_HALF: rd_o = ctrl_i[MC_UNSIGNED] ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                                : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            default: rd_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_cache.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache.
// Revision : 1.0
// ============================================================================
module dmem_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [2:0]            memCtrl,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ack
);
    import dmem_pkg::*;

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - OFFSET_BITS - IDX_W;

    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [SETS-1:0]       valid_q;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]            mem_ctrl_q, mem_ctrl_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic                  w_hit, w_ack, w_misalign;
    logic [DATA_WIDTH-1:0] w_cached, w_ext, w_merged;
    logic                  w_refill_start, w_refill_wr, w_line_done, w_store_wr;

    assign w_idx      = a[OFFSET_BITS +: IDX_W];
    assign w_tag      = a[DATA_WIDTH-1 -: TAG_W];
    assign w_word     = a[3:2];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_ack      = mem_ack && mem_req_q;
    assign w_cached   = data_q[w_idx][w_word];
    assign w_misalign = is_misaligned(memCtrl[1:0], a[1:0]);

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .word_i (w_cached),
        .lsb_i  (a[1:0]),
        .ctrl_i (memCtrl),
        .rd_o   (w_ext)
    );

    // Store-hit merge keeps the cached word coherent with the write-through.
    always_comb begin
        w_merged = w_cached;
        case (memCtrl[1:0])
            MC_BYTE: w_merged[{a[1:0], 3'b000} +: 8]  = wd[7:0];
            MC_HALF: w_merged[{a[1], 4'b0000} +: 16]  = wd[15:0];
            default: w_merged = wd;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_ctrl_d     = mem_ctrl_q;
        mem_wd_d       = mem_wd_q;
        stall          = 1'b0;
        rd             = '0;
        w_refill_start = 1'b0;
        w_refill_wr    = 1'b0;
        w_line_done    = 1'b0;
        w_store_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (we) begin
                    state_d    = WRITE;
                    stall      = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = a;
                    mem_ctrl_d = memCtrl;
                    mem_wd_d   = wd;
                end else if (re) begin
                    if (w_misalign) begin
                        state_d    = BYPASS;
                        stall      = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = a;
                        mem_ctrl_d = memCtrl;
                    end else if (w_hit) begin
                        rd = w_ext;
                    end else begin
                        state_d        = REFILL;
                        stall          = 1'b1;
                        cnt_d          = 2'd0;
                        mem_req_d      = 1'b1;
                        mem_we_d       = 1'b0;
                        mem_addr_d     = {a[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        mem_ctrl_d     = {1'b0, MC_WORD};
                        w_refill_start = 1'b1;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (w_ack) begin
                    w_refill_wr = 1'b1;
                    cnt_d       = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                        w_line_done = 1'b1;
                    end else begin
                        mem_addr_d = {a[DATA_WIDTH-1:OFFSET_BITS], cnt_q + 2'd1, 2'b00};
                    end
                end
            end
            WRITE: begin
                stall = !w_ack;
                if (w_ack) begin
                    w_store_wr = w_hit;
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                end
            end
            BYPASS: begin
                stall = !w_ack;
                if (w_ack) begin
                    rd        = mem_rd;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_ctrl_q <= 3'b000;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_wd_q   <= mem_wd_d;
            // The line is invalid while it is being overwritten word by word.
            if (w_refill_start) valid_q[w_idx] <= 1'b0;
            if (w_line_done)    valid_q[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_refill_wr) data_q[w_idx][cnt_q]  <= mem_rd;
        if (w_store_wr)  data_q[w_idx][w_word] <= w_merged;
        if (w_line_done) tag_q[w_idx]          <= w_tag;
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_ctrl = mem_ctrl_q;
    assign mem_wd   = mem_wd_q;

endmodule
`default_nettype wire

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory stage and the byte-addressable data memory.
- Read hits return in the same cycle.
- Misses refill a 4-word line from the backing memory over a req/ack handshake, with the pipeline stalled.
- Stores and misaligned loads pass straight through to memory.

Parameters:
- DATA_WIDTH, 32, data and address width.
- SETS, 16, number of lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a  in  32  CPU byte address.
- memCtrl  in  3  access control. Bits [1:0] are size: 00 byte, 01 half, 10 word, 11 treated as word. Bit [2] selects zero-extend on loads.
- re  in  1  load request.
- we  in  1  store request; takes priority over re.
- wd  in  32  store data, taken from the LSBs.
- rd  out  32  load result, sign- or zero-extended.
- stall  out  1  CPU must hold a, memCtrl, re, we and wd while this is high.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  backing write.
- mem_addr  out  32  backing byte address.
- mem_ctrl  out  3  backing memCtrl, same encoding as memCtrl.
- mem_wd  out  32  backing write data.
- mem_rd  in  32  backing read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Address split: offset = a[3:0]; index = a[4 +: log2(SETS)]; tag = the remaining upper bits.
- Storage: per line, a valid bit, a tag and 4x32 data words.
- Reset:
  - state = IDLE; all valid bits cleared; refill counter = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_ctrl = 0, mem_wd = 0.
  - rd = 0; stall = 0 when re = we = 0.
  - Data and tag arrays are not reset.
- Misaligned access: half with a[0] = 1, or word with a[1:0] != 00.
- State IDLE:
  - we = 1: go to WRITE; stall = 1.
  - re = 1, misaligned: go to BYPASS; stall = 1.
  - re = 1, valid and tag match (hit): rd = extracted and extended bytes; stall = 0; stay in IDLE.
  - re = 1, miss: go to REFILL with counter = 0; stall = 1.
  - re = we = 0: stall = 0; rd = 0.
- State REFILL:
  - mem_req = 1, mem_we = 0, mem_ctrl = 010.
  - mem_addr = {a[31:4], counter, 2'b00}.
  - On mem_ack: data[index][counter] <= mem_rd; counter increments.
  - On the ack with counter = 3: valid <= 1, tag written, return to IDLE.
  - The next cycle is a hit. Miss penalty = 4 acks + 1 cycle.
  - stall = 1 throughout.
- State WRITE:
  - mem_req = 1, mem_we = 1, mem_addr = a, mem_ctrl = memCtrl, mem_wd = wd.
  - stall = !mem_ack.
  - On mem_ack: if the line hits, merge wd bytes into the cached word per size and a[1:0]. A miss leaves the cache unchanged. Return to IDLE.
- State BYPASS:
  - mem_req = 1, mem_we = 0, mem_addr = a, mem_ctrl = memCtrl.
  - stall = !mem_ack; on mem_ack, rd = mem_rd, passed unmodified because memory already extends.
  - Return to IDLE. The cache is not updated.
- Byte extraction for a hit:
  - byte = word >> (8*a[1:0]).
  - half = word >> (16*a[1]).
  - Sign-extend when memCtrl[2] = 0, else zero-extend.
  - Size 11 with bit [2] set returns the word unmodified.
- Request outputs are registered. mem_req rises the cycle after entering a non-IDLE state and drops the cycle after mem_ack.
- mem_ack while not requesting: ignored.
- Reset mid-REFILL: the partial line stays invalid and mem_req drops next cycle. A late mem_ack after reset is ignored.
- Inputs changing while stall = 1: a protocol violation; the design need not handle it.

Decomposition:
- Package dmem_pkg holds:
  - memCtrl size encodings (MC_BYTE, MC_HALF, MC_WORD) and the MC_UNSIGNED bit index.
  - state enum {IDLE, REFILL, WRITE, BYPASS}.
  - OFFSET_BITS = 4.
- Sub-module load_extend, combinational: inputs word, a[1:0], memCtrl; output the extended rd. It is shared by the hit path.

Test Plan:
- Cold miss then hit: load word at 0x10000, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 on the 4 refill acks. Required: mem_addr 0x10000/4/8/C; rd = 0x11111111 with stall low on the cycle after the 4th ack. A load at 0x10008 then hits with stall = 0 and rd = 0x33333333.
- Extension: cached word 0x80F17FA5 at 0x10010. Required results:
  - lb at 0x10010 -> 0xFFFFFFA5.
  - lbu -> 0x000000A5.
  - lh at 0x10012 -> 0xFFFF80F1.
  - lhu at 0x10012 -> 0x000080F1.
- Store hit: sb 0xEE to 0x10011 on a line cached as in the extension case, with a 2-cycle ack delay. Required:
  - mem_we = 1, mem_ctrl = 000; stall is high until ack.
  - A following lw at 0x10010 hits and returns 0x80F1EEA5.
- Store miss: sw to an uncached 0x20000. Required: one write transaction, no refill, and a subsequent load at 0x20000 misses.
- Misaligned: lw at 0x10013 with memory returning 0xDEADBEEF. Required: a single BYPASS request with mem_addr = 0x10013, rd = 0xDEADBEEF, cache contents unchanged.
- Reset mid-refill: assert rst after 2 acks. Required: mem_req = 0 the next cycle, and a retry of the same load performs a full 4-word refill.
